// File: rtl/tq_pkg.sv
// Shared definitions for the 4x4 dequantization / inverse transform block.
// Holds the FSM state type, the H.264 level-scale table, the coefficient
// widths used at each stage, a generic saturation helper and the QP split.
package tq_pkg;

  localparam int LVL_W = 15;  // signed quantized level
  localparam int RES_W = 9;   // signed residual output
  localparam int INT_W = 16;  // dequantized coefficient saturation width
  localparam int ROW_W = 18;  // coefficient storage width (row-pass results)
  localparam int COL_W = 20;  // column-pass butterfly output width

  typedef enum logic [2:0] {
    IDLE,
    DEQ,
    ROW,
    COL,
    DONE
  } state_e;

  // Level-scale factors V[qp%6][cls]; cls 0 = even/even, 1 = mixed, 2 = odd/odd.
  localparam logic [4:0] V_TAB [6][3] = '{
    '{5'd10, 5'd13, 5'd16},
    '{5'd11, 5'd14, 5'd18},
    '{5'd13, 5'd16, 5'd20},
    '{5'd14, 5'd18, 5'd23},
    '{5'd16, 5'd20, 5'd25},
    '{5'd18, 5'd23, 5'd29}
  };

  // Clamp a signed value to the range of a w-bit two's complement number.
  function automatic logic signed [31:0] sat(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // qp/6, clamped to 8 so out-of-range QPs (52..63) still give bounded shifts.
  function automatic logic [3:0] qp_div6(input logic [5:0] qp);
    logic [5:0] q;
    q = qp / 6'd6;
    if (q > 6'd8) q = 6'd8;
    return 4'(q);
  endfunction

  function automatic logic [2:0] qp_mod6(input logic [5:0] qp);
    return 3'(qp % 6'd6);
  endfunction

endpackage

// File: rtl/tq_idct_1d.sv
// Combinational 4-point H.264 inverse integer butterfly.
//   a0_i..a3_i : signed inputs, IN_W bits
//   o0_o..o3_o : signed outputs, IN_W+2 bits (cannot overflow)
module tq_idct_1d #(
  parameter int IN_W = 18
) (
  input  logic signed [IN_W-1:0] a0_i,
  input  logic signed [IN_W-1:0] a1_i,
  input  logic signed [IN_W-1:0] a2_i,
  input  logic signed [IN_W-1:0] a3_i,
  output logic signed [IN_W+1:0] o0_o,
  output logic signed [IN_W+1:0] o1_o,
  output logic signed [IN_W+1:0] o2_o,
  output logic signed [IN_W+1:0] o3_o
);

  logic signed [IN_W+1:0] x0, x1, x2, x3;
  logic signed [IN_W+1:0] e0, e1, e2, e3;

  // Sign-extend up front so every sum below is evaluated at full output width.
  assign x0 = {{2{a0_i[IN_W-1]}}, a0_i};
  assign x1 = {{2{a1_i[IN_W-1]}}, a1_i};
  assign x2 = {{2{a2_i[IN_W-1]}}, a2_i};
  assign x3 = {{2{a3_i[IN_W-1]}}, a3_i};

  assign e0 = x0 + x2;
  assign e1 = x0 - x2;
  assign e2 = (x1 >>> 1) - x3;
  assign e3 = x1 + (x3 >>> 1);

  assign o0_o = e0 + e3;
  assign o1_o = e1 + e2;
  assign o2_o = e1 - e2;
  assign o3_o = e0 - e3;

endmodule

// File: rtl/tq_dequant_idct.sv
// H.264 4x4 dequantization followed by inverse integer DCT.
// One block is accepted in IDLE, dequantized in one cycle, then transformed
// row by row (4 cycles) and column by column (4 cycles) through one shared
// butterfly; the rounded residuals are held in DONE until the consumer takes them.
//   clk, rst          : clock, asynchronous active-high reset
//   h264_reset        : synchronous clear, same effect as rst
//   in_valid_i/in_ready_o, qp_i, level_i : input block handshake and payload
//   out_valid_o/out_ready_i, res_o       : output block handshake and payload
module tq_dequant_idct
  import tq_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   h264_reset,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [5:0]             qp_i,
  input  logic [16*LVL_W-1:0]    level_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [16*RES_W-1:0]    res_o
);

  state_e                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [3:0]              qpdiv_q, qpdiv_d;
  logic [2:0]              qpmod_q, qpmod_d;
  logic signed [ROW_W-1:0] coef_q [16];
  logic signed [ROW_W-1:0] coef_d [16];
  logic signed [RES_W-1:0] res_q  [16];
  logic signed [RES_W-1:0] res_d  [16];

  logic signed [31:0]      prod    [16];
  logic signed [ROW_W-1:0] deq_w   [16];
  logic signed [ROW_W-1:0] bf_a    [4];
  logic signed [COL_W-1:0] bf_o    [4];
  logic signed [31:0]      rnd     [4];
  logic signed [RES_W-1:0] col_res [4];

  // Scale class of element k = 4*i+j: bit 2 of k is i's parity, bit 0 is j's.
  function automatic logic [1:0] coef_cls(input int k);
    if ((k & 5) == 5) return 2'd2;
    if ((k & 5) == 0) return 2'd0;
    return 2'd1;
  endfunction

  // Dequantization of all 16 coefficients; the level sits in coef_q during DEQ.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      prod[k]  = $signed({{(32-ROW_W){coef_q[k][ROW_W-1]}}, coef_q[k]})
               * $signed({27'd0, V_TAB[qpmod_q][coef_cls(k)]});
      deq_w[k] = ROW_W'(sat(prod[k] <<< qpdiv_q, INT_W));
    end
  end

  // Butterfly operand select: a row of the array in ROW, a column otherwise.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      if (state_q == ROW) bf_a[j] = coef_q[{cnt_q, 2'(j)}];
      else                bf_a[j] = coef_q[{2'(j), cnt_q}];
    end
  end

  tq_idct_1d #(.IN_W(ROW_W)) u_idct_1d (
    .a0_i (bf_a[0]),
    .a1_i (bf_a[1]),
    .a2_i (bf_a[2]),
    .a3_i (bf_a[3]),
    .o0_o (bf_o[0]),
    .o1_o (bf_o[1]),
    .o2_o (bf_o[2]),
    .o3_o (bf_o[3])
  );

  // Final rounding of column results: (x + 32) >>> 6, clipped to 9 bits.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      rnd[j]     = $signed({{(32-COL_W){bf_o[j][COL_W-1]}}, bf_o[j]}) + 32'sd32;
      col_res[j] = RES_W'(sat(rnd[j] >>> 6, RES_W));
    end
  end

  always_comb begin
    // NOTE: every *_d starts as its *_q so no path through the case leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    qpdiv_d = qpdiv_q;
    qpmod_d = qpmod_q;
    coef_d  = coef_q;
    res_d   = res_q;

    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          for (int k = 0; k < 16; k++) begin
            coef_d[k] = {{(ROW_W-LVL_W){level_i[LVL_W*k+LVL_W-1]}}, level_i[LVL_W*k +: LVL_W]};
          end
          qpdiv_d = qp_div6(qp_i);
          qpmod_d = qp_mod6(qp_i);
          state_d = DEQ;
        end
      end
      DEQ: begin
        coef_d  = deq_w;
        cnt_d   = 2'd0;
        state_d = ROW;
      end
      ROW: begin
        // Row results always fit in ROW_W bits, so the top two bits are dropped.
        for (int j = 0; j < 4; j++) coef_d[{cnt_q, 2'(j)}] = bf_o[j][ROW_W-1:0];
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = COL;
      end
      COL: begin
        for (int j = 0; j < 4; j++) res_d[{2'(j), cnt_q}] = col_res[j];
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Synchronous clear overrides everything, including a same-edge accept.
    if (h264_reset) begin
      state_d = IDLE;
      cnt_d   = 2'd0;
      qpdiv_d = 4'd0;
      qpmod_d = 3'd0;
      coef_d  = '{default: '0};
      res_d   = '{default: '0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      qpdiv_q <= 4'd0;
      qpmod_q <= 3'd0;
      // NOTE: the coefficient and residual arrays are plain flops, not RAM,
      // and must read back as zero after reset, so they are cleared here.
      coef_q  <= '{default: '0};
      res_q   <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qpdiv_q <= qpdiv_d;
      qpmod_q <= qpmod_d;
      coef_q  <= coef_d;
      res_q   <= res_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);

  for (genvar k = 0; k < 16; k++) begin : g_res
    assign res_o[RES_W*k +: RES_W] = res_q[k];
  end

endmodule
